// File: rtl/maxpool_relu_pkg.sv
// Shared constants and helpers for the ReLU + 2x2 max-pool stage.
package maxpool_relu_pkg;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_IMG_W  = 24;
  localparam int DEF_IMG_H  = 24;
  localparam int POOL_W     = DEF_IMG_W / 2;
  localparam int COL_W      = $clog2(DEF_IMG_W);

  // Wide enough for any lane width; callers sign-extend in and truncate out.
  localparam int SMAX_W     = 32;

  // Signed maximum; on a tie both operands are equal so either is returned.
  function automatic logic signed [SMAX_W-1:0] smax(input logic signed [SMAX_W-1:0] a,
                                                    input logic signed [SMAX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_relu_if.sv
// Pixel stream from the conv stage in, pooled pixel stream out.
interface maxpool_relu_if
  import maxpool_relu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic                     valid_in;
  logic signed [DATA_W-1:0] conv_out_1;
  logic signed [DATA_W-1:0] conv_out_2;
  logic signed [DATA_W-1:0] conv_out_3;
  logic signed [DATA_W-1:0] max_value_1;
  logic signed [DATA_W-1:0] max_value_2;
  logic signed [DATA_W-1:0] max_value_3;
  logic                     valid_out;

  // Upstream side: drives pixels, observes pooled results.
  modport master (
    output valid_in, conv_out_1, conv_out_2, conv_out_3,
    input  max_value_1, max_value_2, max_value_3, valid_out
  );

  // Pooling block side.
  modport slave (
    input  valid_in, conv_out_1, conv_out_2, conv_out_3,
    output max_value_1, max_value_2, max_value_3, valid_out
  );

endinterface

// File: rtl/maxpool_relu_lane.sv
// One channel of 2x2/stride-2 max pooling with ReLU on the pooled value.
// The horizontal pair max of each even row is parked in rowbuf and combined
// with the matching pair of the following odd row.
module maxpool_relu_lane
  import maxpool_relu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = DEF_IMG_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [DATA_W-1:0]    x,
  input  logic                        we_pair,
  input  logic                        we_row,
  input  logic                        emit,
  input  logic [$clog2(IMG_W)-2:0]    idx,
  output logic signed [DATA_W-1:0]    max_value
);

  localparam int NPOOL = IMG_W / 2;

  logic signed [DATA_W-1:0] pair_p0;
  logic signed [DATA_W-1:0] rowbuf_p0 [NPOOL];
  logic signed [DATA_W-1:0] max_p1;
  logic signed [DATA_W-1:0] hmax;
  logic signed [DATA_W-1:0] vmax;

  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? '0 : v;
  endfunction

  function automatic logic signed [DATA_W-1:0] max2(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return DATA_W'(smax(SMAX_W'(a), SMAX_W'(b)));
  endfunction

  assign hmax = max2(pair_p0, x);
  assign vmax = max2(hmax, rowbuf_p0[idx]);

  // Stage p0 -> p1: capture left pixel, park even-row pair max, emit pooled result.
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_p0 <= '0;
      for (int i = 0; i < NPOOL; i++) rowbuf_p0[i] <= '0;
      max_p1  <= '0;
    end else begin
      if (we_pair) pair_p0        <= x;
      if (we_row)  rowbuf_p0[idx] <= hmax;
      if (emit)    max_p1         <= relu(vmax);
    end
  end

  assign max_value = max_p1;

endmodule

// File: rtl/maxpool_relu.sv
// ReLU + 2x2/stride-2 max pooling over three conv channels streamed in raster
// order. Position counters decide the role of each pixel inside its window;
// three identical lanes hold the per-channel data path.
module maxpool_relu
  import maxpool_relu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H
) (
  input  logic          clk,
  input  logic          rst,
  maxpool_relu_if.slave bus
);

  localparam int CNT_CW = $clog2(IMG_W);
  localparam int CNT_RW = $clog2(IMG_H);
  localparam int IDX_W  = CNT_CW - 1;

  logic [CNT_CW-1:0]        col_p0;
  logic [CNT_RW-1:0]        row_p0;
  logic                     vld_p1;
  logic                     we_pair;
  logic                     we_row;
  logic                     emit;
  logic [IDX_W-1:0]         idx;
  logic signed [DATA_W-1:0] max1;
  logic signed [DATA_W-1:0] max2;
  logic signed [DATA_W-1:0] max3;

  // Window phase: even column starts a pair, odd column closes it; odd rows finish the window.
  assign we_pair = bus.valid_in & ~col_p0[0];
  assign we_row  = bus.valid_in &  col_p0[0] & ~row_p0[0];
  assign emit    = bus.valid_in &  col_p0[0] &  row_p0[0];
  assign idx     = col_p0[CNT_CW-1:1];

  // Raster position of the incoming pixel; frozen while valid_in is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_p0 <= '0;
      row_p0 <= '0;
    end else if (bus.valid_in) begin
      if (col_p0 == CNT_CW'(IMG_W - 1)) begin
        col_p0 <= '0;
        row_p0 <= (row_p0 == CNT_RW'(IMG_H - 1)) ? '0 : row_p0 + 1'b1;
      end else begin
        col_p0 <= col_p0 + 1'b1;
      end
    end
  end

  // Stage p0 -> p1: strobe alongside the registered pooled values.
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= emit;
  end

  maxpool_relu_lane #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_lane1 (
    .clk(clk), .rst(rst), .x(bus.conv_out_1), .we_pair(we_pair), .we_row(we_row),
    .emit(emit), .idx(idx), .max_value(max1)
  );

  maxpool_relu_lane #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_lane2 (
    .clk(clk), .rst(rst), .x(bus.conv_out_2), .we_pair(we_pair), .we_row(we_row),
    .emit(emit), .idx(idx), .max_value(max2)
  );

  maxpool_relu_lane #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_lane3 (
    .clk(clk), .rst(rst), .x(bus.conv_out_3), .we_pair(we_pair), .we_row(we_row),
    .emit(emit), .idx(idx), .max_value(max3)
  );

  assign bus.max_value_1 = max1;
  assign bus.max_value_2 = max2;
  assign bus.max_value_3 = max3;
  assign bus.valid_out   = vld_p1;

endmodule

// File: tb/tb_maxpool_relu.sv
// Bench for maxpool_relu: a frame-level model stores every received pixel and,
// whenever a pixel completes a 2x2 window, schedules the ReLU'd window maximum
// for the next clock. One compare process checks every cycle.
module tb_maxpool_relu;

  localparam int DW = 12;
  localparam int W  = 24;
  localparam int H  = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  maxpool_relu_if #(.DATA_W(DW)) bus ();

  maxpool_relu #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  int fr [3][H][W];
  int mr = 0, mc = 0;
  bit armed = 0;
  bit pend_rst = 0, pend_emit = 0;
  int pend_m [3];
  bit exp_vld = 0;
  int exp_m [3] = '{0, 0, 0};
  int seen1[$], seen2[$], seen3[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Pixel pattern generator per test mode.
  function automatic int val(input int mode, input int ch, input int r, input int c);
    int v;
    v = 0;
    case (mode)
      1: if (ch == 0) begin
           if (r == 0 && c == 0) v = 5;
           if (r == 0 && c == 1) v = -3;
           if (r == 1 && c == 0) v = 100;
           if (r == 1 && c == 1) v = 7;
         end
      2: v = (ch == 0) ? 0 : (ch == 1) ? -50 : 2047;
      3: v = (ch == 0) ? r * W + c : (ch == 1) ? c - 2 * r : ((r * 7 + c * 13) % 50) - 25;
      4: v = 1;
      5: v = 9;
      6: v = ((r * 37 + c * 11 + ch * 5) % 400) - 200;
      default: v = 0;
    endcase
    return v;
  endfunction

  // Drive one cycle of input and advance the model accordingly.
  task automatic cyc(input bit v, input int a, input int b, input int c, input bit r);
    int m;
    int px [3];
    @(negedge clk);
    rst            = r;
    bus.valid_in   = v;
    bus.conv_out_1 = DW'(a);
    bus.conv_out_2 = DW'(b);
    bus.conv_out_3 = DW'(c);
    px = '{a, b, c};
    pend_rst  = r;
    pend_emit = 0;
    if (r) begin
      armed = 1;
      mr = 0;
      mc = 0;
    end else if (v) begin
      for (int ch = 0; ch < 3; ch++) fr[ch][mr][mc] = px[ch];
      if (mr % 2 == 1 && mc % 2 == 1) begin
        for (int ch = 0; ch < 3; ch++) begin
          m = fr[ch][mr][mc];
          if (fr[ch][mr][mc-1] > m)   m = fr[ch][mr][mc-1];
          if (fr[ch][mr-1][mc] > m)   m = fr[ch][mr-1][mc];
          if (fr[ch][mr-1][mc-1] > m) m = fr[ch][mr-1][mc-1];
          pend_m[ch] = (m < 0) ? 0 : m;
        end
        pend_emit = 1;
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) mr = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 777, -777, 123, 0);
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 1);
  endtask

  task automatic frame(input int mode, input bit toggle);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        cyc(1, val(mode, 0, r, c), val(mode, 1, r, c), val(mode, 2, r, c), 0);
        if (toggle) idle(1);
      end
  endtask

  task automatic clear_seen();
    seen1.delete();
    seen2.delete();
    seen3.delete();
  endtask

  function automatic int seen_at(input int ch, input int k);
    if (ch == 0) return (k < seen1.size()) ? seen1[k] : -99999;
    if (ch == 1) return (k < seen2.size()) ? seen2[k] : -99999;
    return (k < seen3.size()) ? seen3[k] : -99999;
  endfunction

  // Every-cycle compare against the model, 1 time unit after the active edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (armed) begin
      if (pend_rst) begin
        exp_vld = 0;
        exp_m   = '{0, 0, 0};
      end else begin
        exp_vld = pend_emit;
        if (pend_emit) exp_m = pend_m;
      end
      chk("valid_out",   int'(bus.valid_out),   int'(exp_vld));
      chk("max_value_1", int'(bus.max_value_1), exp_m[0]);
      chk("max_value_2", int'(bus.max_value_2), exp_m[1]);
      chk("max_value_3", int'(bus.max_value_3), exp_m[2]);
      if (bus.valid_out === 1'b1) begin
        seen1.push_back(int'(bus.max_value_1));
        seen2.push_back(int'(bus.max_value_2));
        seen3.push_back(int'(bus.max_value_3));
      end
    end
  end

  initial begin
    bus.valid_in   = 1'b0;
    bus.conv_out_1 = '0;
    bus.conv_out_2 = '0;
    bus.conv_out_3 = '0;

    // 1: reset state, then an all-zero frame
    do_reset();
    idle(1);
    chk("reset_valid_out", int'(bus.valid_out), 0);
    chk("reset_max1", int'(bus.max_value_1), 0);
    chk("reset_max3", int'(bus.max_value_3), 0);
    clear_seen();
    frame(0, 0);
    idle(2);
    chk("zero_frame_strobes", seen1.size(), 144);

    // 2: single hand-built window on ch1
    do_reset();
    clear_seen();
    frame(1, 0);
    idle(2);
    chk("window_first", seen_at(0, 0), 100);
    chk("window_second", seen_at(0, 1), 0);
    chk("window_strobes", seen1.size(), 144);

    // 3: ReLU clamps negatives; positive full-scale passes
    do_reset();
    clear_seen();
    frame(2, 0);
    idle(2);
    chk("relu_neg_ch2", seen_at(1, 77), 0);
    chk("pos_max_ch3", seen_at(2, 143), 2047);

    // 4: ramp with valid_in toggling every clock
    do_reset();
    clear_seen();
    frame(3, 1);
    idle(2);
    chk("ramp_strobes", seen1.size(), 144);
    chk("ramp_first", seen_at(0, 0), 25);
    chk("ramp_k13", seen_at(0, 13), 75);
    chk("ramp_last", seen_at(0, 143), 575);

    // 5: two frames back-to-back, second all ones
    do_reset();
    clear_seen();
    frame(3, 0);
    frame(4, 0);
    idle(2);
    chk("two_frame_strobes", seen1.size(), 288);
    chk("frame1_last", seen_at(0, 143), 575);
    chk("frame2_first", seen_at(0, 144), 1);
    chk("frame2_last", seen_at(0, 287), 1);

    // 6: reset mid-frame at row 5 col 9 coincident with valid_in
    do_reset();
    clear_seen();
    begin
      bit done;
      done = 0;
      for (int r = 0; r < H && !done; r++)
        for (int c = 0; c < W && !done; c++) begin
          if (r == 5 && c == 9) begin
            cyc(1, 500, 500, 500, 1);
            done = 1;
          end else begin
            cyc(1, val(6, 0, r, c), val(6, 1, r, c), val(6, 2, r, c), 0);
          end
        end
    end
    idle(2);
    chk("partial_strobes", seen1.size(), 28);
    clear_seen();
    frame(5, 0);
    idle(2);
    chk("after_reset_strobes", seen1.size(), 144);
    chk("after_reset_first", seen_at(0, 0), 9);
    chk("after_reset_last_ch3", seen_at(2, 143), 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
